// File: rtl/strided_merge_gen_if.sv
// Control, configuration and merged-stream signals of strided_merge_gen.
// The bench drives through master; the merge unit attaches as slave.
interface strided_merge_gen_if #(
  parameter int NUM_INPUTS = 16,
  parameter int DATA_W     = 32,
  parameter int DELAY_W    = 8,
  parameter int STRIDE_W   = 8,
  parameter int PASS_W     = 16
);
  localparam int SEL_W = $clog2(NUM_INPUTS);

  logic                         run;
  logic                         running;
  logic [NUM_INPUTS*DATA_W-1:0] in_flat;
  logic [NUM_INPUTS-1:0]        chan_en;
  logic [STRIDE_W-1:0]          stride;
  logic [DELAY_W-1:0]           delay0;
  logic [PASS_W-1:0]            passes;
  logic                         reverse;
  logic [DATA_W-1:0]            out0;
  logic                         out_valid;
  logic [SEL_W-1:0]             sel;
  logic                         done;

  modport master (
    output run, running, in_flat, chan_en, stride, delay0, passes, reverse,
    input  out0, out_valid, sel, done
  );

  modport slave (
    input  run, running, in_flat, chan_en, stride, delay0, passes, reverse,
    output out0, out_valid, sel, done
  );
endinterface

// File: rtl/strided_merge_gen.sv
// Time-multiplexing merge: serialises the enabled channels onto one registered
// stream, holding each for stride+1 cycles after a start delay, for a pass count.
module strided_merge_gen #(
  parameter int NUM_INPUTS = 16,
  parameter int DATA_W     = 32,
  parameter int DELAY_W    = 8,
  parameter int STRIDE_W   = 8,
  parameter int PASS_W     = 16
) (
  input logic                clk,
  input logic                rst,
  strided_merge_gen_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_INPUTS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] MERGE  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]            r_state;
  logic [DELAY_W-1:0]    r_dcnt;
  logic [STRIDE_W-1:0]   r_scnt;
  logic [STRIDE_W-1:0]   r_stride;
  logic [PASS_W-1:0]     r_pcnt;
  logic [PASS_W-1:0]     r_passes;
  logic [NUM_INPUTS-1:0] r_en;
  logic                  r_rev;
  logic [SEL_W-1:0]      r_chan;
  logic [SEL_W-1:0]      r_sel;
  logic [DATA_W-1:0]     r_out0;
  logic                  r_valid;
  logic                  r_done;

  logic [DATA_W-1:0]     w_in_arr [NUM_INPUTS];
  logic [SEL_W-1:0]      w_first;
  logic [SEL_W-1:0]      w_next;
  logic                  w_wrap;
  logic                  w_start;
  logic [PASS_W-1:0]     w_pcnt_inc;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_unpack
    assign w_in_arr[g] = bus.in_flat[g*DATA_W +: DATA_W];
  end

  assign w_start    = bus.run && bus.running;
  assign w_pcnt_inc = r_pcnt + 1'b1;

  // First enabled channel in the latched order, and the next one after r_chan;
  // running off the end of the order wraps back to the first and marks a pass.
  always_comb begin
    w_first = '0;
    w_next  = '0;
    w_wrap  = 1'b1;
    if (!r_rev) begin
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        if (r_en[i]) w_first = SEL_W'(i);
        if (r_en[i] && (SEL_W'(i) > r_chan)) begin
          w_next = SEL_W'(i);
          w_wrap = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (r_en[i]) w_first = SEL_W'(i);
        if (r_en[i] && (SEL_W'(i) < r_chan)) begin
          w_next = SEL_W'(i);
          w_wrap = 1'b0;
        end
      end
    end
    if (w_wrap) w_next = w_first;
  end

  // Dropping running aborts from any busy state; a run while busy restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_dcnt   <= '0;
      r_scnt   <= '0;
      r_stride <= '0;
      r_pcnt   <= '0;
      r_passes <= '0;
      r_en     <= '0;
      r_rev    <= 1'b0;
      r_chan   <= '0;
      r_sel    <= '0;
      r_out0   <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != IDLE) && !bus.running) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
      end else if (w_start) begin
        r_en     <= bus.chan_en;
        r_stride <= bus.stride;
        r_passes <= bus.passes;
        r_rev    <= bus.reverse;
        r_dcnt   <= bus.delay0;
        r_state  <= DELAY;
        r_valid  <= 1'b0;
        if (r_state == FINISH) r_done <= 1'b1;
      end else begin
        case (r_state)
          IDLE: r_valid <= 1'b0;
          DELAY: begin
            r_valid <= 1'b0;
            if (r_dcnt == '0) begin
              if (r_en == '0) begin
                r_state <= FINISH;
              end else begin
                r_chan  <= w_first;
                r_scnt  <= '0;
                r_pcnt  <= '0;
                r_state <= MERGE;
              end
            end else begin
              r_dcnt <= r_dcnt - 1'b1;
            end
          end
          MERGE: begin
            r_out0  <= w_in_arr[r_chan];
            r_sel   <= r_chan;
            r_valid <= 1'b1;
            if (r_scnt == r_stride) begin
              r_scnt <= '0;
              r_chan <= w_next;
              if (w_wrap) begin
                r_pcnt <= w_pcnt_inc;
                if ((r_passes != '0) && (w_pcnt_inc == r_passes)) r_state <= FINISH;
              end
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
          FINISH: begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out0      = r_out0;
  assign bus.out_valid = r_valid;
  assign bus.sel       = r_sel;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_strided_merge_gen.sv
// Scoreboard bench for strided_merge_gen: expected (data, sel) pairs are queued
// when a run is issued and popped by a negedge monitor on every valid cycle.
module tb_strided_merge_gen;
  localparam int NI  = 16;
  localparam int DW  = 8;
  localparam int DLW = 8;
  localparam int SW  = 8;
  localparam int PW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  strided_merge_gen_if #(
    .NUM_INPUTS(NI), .DATA_W(DW), .DELAY_W(DLW), .STRIDE_W(SW), .PASS_W(PW)
  ) bus ();

  strided_merge_gen #(
    .NUM_INPUTS(NI), .DATA_W(DW), .DELAY_W(DLW), .STRIDE_W(SW), .PASS_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [3:0]    sel;
  } exp_t;

  exp_t sb[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cyc         = 0;
  int   runEdge     = 0;
  int   firstValid  = -1;
  int   validCount  = 0;
  int   doneCount   = 0;
  int   doneCycle   = -1;
  int   expValid    = 0;
  int   expDelay    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Every valid beat must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus.out_valid) begin
        validCount++;
        if (firstValid < 0) firstValid = cyc;
        if (sb.size() == 0) begin
          checkOutput("extra_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("out0", 32'(bus.out0), 32'(e.data));
          checkOutput("sel", 32'(bus.sel), 32'(e.sel));
        end
      end
      if (bus.done) begin
        doneCount++;
        doneCycle = cyc;
      end
    end
  end

  task automatic applyStimulus(input logic [NI-1:0] en, input logic [SW-1:0] stride,
                               input logic [DLW-1:0] delay0, input logic [PW-1:0] passes,
                               input logic rev, input int modelPasses);
    int   order[$];
    exp_t e;
    if (!rev) begin
      for (int i = 0; i < NI; i++) if (en[i]) order.push_back(i);
    end else begin
      for (int i = NI - 1; i >= 0; i--) if (en[i]) order.push_back(i);
    end
    for (int p = 0; p < modelPasses; p++) begin
      foreach (order[j]) begin
        for (int s = 0; s <= int'(stride); s++) begin
          e.data = DW'(order[j]);
          e.sel  = 4'(order[j]);
          sb.push_back(e);
        end
      end
    end
    expValid   = sb.size();
    expDelay   = int'(delay0);
    validCount = 0;
    doneCount  = 0;
    doneCycle  = -1;
    firstValid = -1;
    bus.chan_en = en;
    bus.stride  = stride;
    bus.delay0  = delay0;
    bus.passes  = passes;
    bus.reverse = rev;
    bus.run     = 1'b1;
    @(posedge clk);
    #1;
    runEdge = cyc;
    bus.run = 1'b0;
    bus.chan_en = ~en;
    bus.stride  = stride + 8'd3;
    bus.delay0  = delay0 + 8'd5;
    bus.passes  = passes + 16'd1;
    bus.reverse = ~rev;
  endtask

  task automatic finishRun();
    int budget;
    int n;
    budget = expValid + expDelay + 40;
    n = 0;
    while (doneCount == 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("done_seen", 32'(doneCount), 32'd1);
    checkOutput("done_cycle", 32'(doneCycle), 32'(runEdge + expDelay + 2 + expValid));
    checkOutput("valid_count", 32'(validCount), 32'(expValid));
    checkOutput("sb_left", 32'(sb.size()), 32'd0);
    if (expValid > 0) checkOutput("first_valid", 32'(firstValid), 32'(runEdge + expDelay + 2));
    else              checkOutput("first_valid", 32'(firstValid), 32'hFFFF_FFFF);
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("idle_valid", 32'(bus.out_valid), 32'd0);
    end
    checkOutput("done_count", 32'(doneCount), 32'd1);
    sb.delete();
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    bus.run     = 1'b0;
    bus.running = 1'b1;
    bus.chan_en = '0;
    bus.stride  = '0;
    bus.delay0  = '0;
    bus.passes  = '0;
    bus.reverse = 1'b0;
    for (int i = 0; i < NI; i++) bus.in_flat[i*DW +: DW] = DW'(i);

    #12;
    checkOutput("rst_out0", 32'(bus.out0), 32'd0);
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_sel", 32'(bus.sel), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] ascending, stride 0, one pass");
    applyStimulus(16'hFFFF, 8'd0, 8'd0, 16'd1, 1'b0, 1);
    finishRun();

    $display("[TB] stride 3, delay 3, two passes");
    applyStimulus(16'hFFFF, 8'd3, 8'd3, 16'd2, 1'b0, 2);
    finishRun();

    $display("[TB] sparse mask, descending, stride 1");
    applyStimulus(16'h8421, 8'd1, 8'd0, 16'd1, 1'b1, 1);
    finishRun();

    $display("[TB] empty mask, delay 2");
    applyStimulus(16'h0000, 8'd0, 8'd2, 16'd1, 1'b0, 1);
    finishRun();

    $display("[TB] continuous mode, abort at channel 7");
    for (int i = 0; i < 8; i++) begin
      e.data = DW'(i);
      e.sel  = 4'(i);
      sb.push_back(e);
    end
    applyStimulus(16'hFFFF, 8'd0, 8'd0, 16'd0, 1'b0, 0);
    waitDrain("abort_reach7", 100);
    bus.running = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_sel", 32'(bus.sel), 32'd7);
    checkOutput("abort_out0", 32'(bus.out0), 32'd7);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("abort_no_done", 32'(doneCount), 32'd0);
    checkOutput("abort_valid_count", 32'(validCount), 32'd8);
    bus.running = 1'b1;
    @(negedge clk);
    applyStimulus(16'hFFFF, 8'd0, 8'd0, 16'd1, 1'b0, 1);
    finishRun();

    $display("[TB] asynchronous reset mid-merge");
    for (int i = 0; i < 3; i++) begin
      e.data = DW'(i);
      e.sel  = 4'(i);
      sb.push_back(e);
      sb.push_back(e);
    end
    applyStimulus(16'hFFFF, 8'd1, 8'd0, 16'd0, 1'b0, 0);
    waitDrain("rst_mid_reach", 100);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_out0", 32'(bus.out0), 32'd0);
    checkOutput("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_mid_sel", 32'(bus.sel), 32'd0);
    checkOutput("rst_mid_done", 32'(bus.done), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(16'h0F0F, 8'd0, 8'd1, 16'd1, 1'b0, 1);
    finishRun();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
